// File: rtl/fir.sv
// -----------------------------------------------------------------------------
// fir -- direct-form FIR filter with constant signed coefficients.
//
// Sits in the receive datapath after the channel model. Each valid strobe
// pushes one sample into a FIR_LEN-deep delay line. Every enabled cycle the
// output register recomputes sum(h[k] * x[k]) from the registered taps. The
// sum is truncated toward -inf, saturated to NB_OUT bits and registered.
//
// Ports
//   clk        in   1        rising-edge clock
//   i_reset    in   1        synchronous active-high reset (taps and output)
//   i_is_data  in   NB_IN    signed input sample S(NB_IN, NBF_IN)
//   i_en       in   1        global enable; 0 freezes every register
//   i_valid    in   1        sample strobe; shifts the delay line when i_en=1
//   o_sample   out  NB_OUT   signed filtered sample S(NB_OUT, NBF_OUT)
//
// Coefficients: h[k] = COEFFS[k*NB_COEFF +: NB_COEFF], format S(NB_COEFF,
// NBF_COEFF). The default is a 0.25 / 0.5 / 0.25 smoother centred on the
// middle tap.
// -----------------------------------------------------------------------------
module fir #(
   parameter int FIR_LEN   = 21,
   parameter int NB_COEFF  = 8,
   parameter int NBF_COEFF = 7,
   parameter int NB_IN     = 18,
   parameter int NBF_IN    = 15,
   parameter int NB_OUT    = 18,
   parameter int NBF_OUT   = 15,
   parameter logic [FIR_LEN*NB_COEFF-1:0] COEFFS =
        ((FIR_LEN*NB_COEFF)'(8'h20) << ((FIR_LEN/2 - 1) * NB_COEFF))
      | ((FIR_LEN*NB_COEFF)'(8'h40) << ((FIR_LEN/2)     * NB_COEFF))
      | ((FIR_LEN*NB_COEFF)'(8'h20) << ((FIR_LEN/2 + 1) * NB_COEFF))
) (
   input  logic                     clk,
   input  logic                     i_reset,
   input  logic signed [NB_IN-1:0]  i_is_data,
   input  logic                     i_en,
   input  logic                     i_valid,
   output logic signed [NB_OUT-1:0] o_sample
);

   // Full-precision product, guarded accumulator, and the width left after
   // dropping the surplus fractional bits.
   localparam int NB_PROD  = NB_IN + NB_COEFF;
   localparam int NBF_PROD = NBF_IN + NBF_COEFF;
   localparam int NB_GUARD = $clog2(FIR_LEN);
   localparam int NB_ACC   = NB_PROD + NB_GUARD;
   localparam int SHIFT    = NBF_PROD - NBF_OUT;
   localparam int NB_SHR   = NB_ACC - SHIFT;

   // Saturation limits expressed at the post-shift width. NB_SHR is at least
   // NB_OUT for any sensible format (the product alone carries NB_IN+NB_COEFF
   // integer-plus-fraction bits).
   localparam logic signed [NB_SHR-1:0] SAT_MAX =
      {{(NB_SHR-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}};
   localparam logic signed [NB_SHR-1:0] SAT_MIN =
      {{(NB_SHR-NB_OUT+1){1'b1}}, {(NB_OUT-1){1'b0}}};

   // Dropping the low SHIFT bits of a two's-complement value is an
   // arithmetic right shift, i.e. rounding toward -inf.
   function automatic logic signed [NB_SHR-1:0] trunc_lsbs(
      input logic signed [NB_ACC-1:0] a
   );
      return a[NB_ACC-1:SHIFT];
   endfunction

   function automatic logic signed [NB_OUT-1:0] saturate(
      input logic signed [NB_SHR-1:0] v
   );
      logic signed [NB_OUT-1:0] r;
      if (v > SAT_MAX) begin
         r = SAT_MAX[NB_OUT-1:0];
      end else if (v < SAT_MIN) begin
         r = SAT_MIN[NB_OUT-1:0];
      end else begin
         r = v[NB_OUT-1:0];
      end
      return r;
   endfunction

   logic signed [NB_IN-1:0]   x_q [FIR_LEN];
   logic signed [NB_IN-1:0]   x_d [FIR_LEN];
   logic signed [NB_PROD-1:0] prod [FIR_LEN];
   logic signed [NB_ACC-1:0]  acc;
   logic signed [NB_OUT-1:0]  o_sample_q;
   logic signed [NB_OUT-1:0]  o_sample_d;

   // Per-tap constant multipliers. Both operands are widened to the product
   // width first so the multiply is carried out at full signed precision.
   for (genvar k = 0; k < FIR_LEN; k++) begin : g_tap
      localparam logic signed [NB_COEFF-1:0] H = COEFFS[k*NB_COEFF +: NB_COEFF];
      assign prod[k] = NB_PROD'(x_q[k]) * NB_PROD'(H);
   end

   // Linear adder chain; the guard bits make every partial sum exact.
   always_comb begin
      acc = '0;
      for (int k = 0; k < FIR_LEN; k++) begin
         acc = acc + NB_ACC'(prod[k]);
      end
   end

   // Next state: the delay line shifts only on a strobe, while the output is
   // recomputed from the pre-shift taps on every enabled edge.
   always_comb begin
      x_d = x_q;
      if (i_valid) begin
         x_d[0] = i_is_data;
         for (int k = 1; k < FIR_LEN; k++) begin
            x_d[k] = x_q[k-1];
         end
      end
      o_sample_d = saturate(trunc_lsbs(acc));
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         x_q        <= '{default: '0};
         o_sample_q <= '0;
      end else if (i_en) begin
         x_q        <= x_d;
         o_sample_q <= o_sample_d;
      end
   end

   assign o_sample = o_sample_q;

endmodule

// File: tb/tb_fir.sv
// -----------------------------------------------------------------------------
// tb_fir -- scoreboard bench for fir.
//
// The stimulus process drives one input vector per cycle and pushes the
// expected o_sample for the following edge into a queue. The monitor pops one
// entry after every rising edge and compares it against the DUT. Directed
// phases supply hand-derived values. The random phase uses an integer
// reference model. A second instance with all coefficients at 0x7F exercises
// saturation.
// -----------------------------------------------------------------------------
module tb_fir;

   logic               clk;
   logic               i_reset;
   logic signed [17:0] i_is_data;
   logic               i_en;
   logic               i_valid;
   logic signed [17:0] o_sample;
   logic signed [17:0] o_sample_sat;

   fir dut (
      .clk       (clk),
      .i_reset   (i_reset),
      .i_is_data (i_is_data),
      .i_en      (i_en),
      .i_valid   (i_valid),
      .o_sample  (o_sample)
   );

   fir #(.COEFFS({21{8'h7F}})) dut_sat (
      .clk       (clk),
      .i_reset   (i_reset),
      .i_is_data (i_is_data),
      .i_en      (i_en),
      .i_valid   (i_valid),
      .o_sample  (o_sample_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int e0;
      bit c1;
      int e1;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state (default coefficients).
   int x_m[21];
   int h_m[21];
   int out_m;

   function automatic int model_out();
      longint acc;
      acc = 0;
      for (int k = 0; k < 21; k++) acc += longint'(x_m[k]) * longint'(h_m[k]);
      acc = acc >>> 7;
      if (acc > 131071)  acc = 131071;
      if (acc < -131072) acc = -131072;
      return int'(acc);
   endfunction

   // Hand-derived impulse response: an impulse sitting at tap position 'tap'
   // before the edge meets h[9]=0.25, h[10]=0.5, h[11]=0.25.
   function automatic int imp_exp(input int tap, input bit neg);
      if (tap < 9 || tap > 11) return 0;
      if (neg) return -1;
      return (tap == 10) ? 16384 : 8192;
   endfunction

   task automatic step(input int d, input bit v, input bit en, input bit rst,
                       input bit use_hand, input int hand,
                       input bit c1, input int e1);
      exp_t e;
      i_is_data = d[17:0];
      i_valid   = v;
      i_en      = en;
      i_reset   = rst;
      if (rst) begin
         foreach (x_m[k]) x_m[k] = 0;
         out_m = 0;
      end else if (en) begin
         out_m = model_out();
         if (v) begin
            for (int k = 20; k > 0; k--) x_m[k] = x_m[k-1];
            x_m[0] = d;
         end
      end
      e.e0 = use_hand ? hand : out_m;
      e.c1 = c1;
      e.e1 = e1;
      q.push_back(e);
      @(negedge clk);
   endtask

   // Impulse of amplitude amp at edge 0, zeros afterwards. An optional window
   // either drops i_valid (gap_en=0) or drops i_en while pulsing i_valid with
   // nonzero data (gap_en=1).
   task automatic run_imp(input int amp, input bit neg,
                          input int gap_start, input int gap_len, input bit gap_en);
      int  tap;
      int  cur;
      bit  in_gap, v, en;
      int  d;
      tap = -1;
      cur = 0;
      for (int j = 0; j < 32; j++) begin
         in_gap = (j >= gap_start) && (j < gap_start + gap_len);
         en = !(in_gap && gap_en);
         v  = in_gap ? (gap_en ? j[0] : 1'b0) : 1'b1;
         d  = (j == 0) ? amp : ((in_gap && gap_en) ? 5000 : 0);
         if (en) cur = imp_exp(tap, neg);
         step(d, v, en, 1'b0, 1'b1, cur, 1'b0, 0);
         if (en && v) tap++;
      end
   endtask

   // Monitor: one expectation per rising edge, sampled just after the edge.
   exp_t               mon_e;
   logic signed [17:0] mon_x;
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         mon_x = mon_e.e0[17:0];
         checks++;
         if (o_sample !== mon_x) begin
            errors++;
            $display("FAIL o_sample t=%0t got %0d expected %0d", $time, o_sample, mon_x);
         end
         if (mon_e.c1) begin
            mon_x = mon_e.e1[17:0];
            checks++;
            if (o_sample_sat !== mon_x) begin
               errors++;
               $display("FAIL sat_sample t=%0t got %0d expected %0d", $time, o_sample_sat, mon_x);
            end
         end
      end
   end

   initial begin
      int d;
      foreach (h_m[k]) h_m[k] = 0;
      h_m[9] = 32; h_m[10] = 64; h_m[11] = 32;
      foreach (x_m[k]) x_m[k] = 0;
      out_m = 0;

      // Initial reset, then random history, then a 2-cycle mid-stream reset
      // with random inputs: output and second instance must read zero.
      step(0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1, 0);
      for (int j = 0; j < 8; j++) begin
         d = int'($urandom_range(0, 262143)) - 131072;
         step(d, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
      end
      for (int j = 0; j < 2; j++) begin
         d = int'($urandom_range(0, 262143)) - 131072;
         step(d, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 0);
      end

      // Positive and negative impulses, then valid-gap and enable-gap runs.
      run_imp(32768, 1'b0, 99, 0, 1'b0);
      run_imp(-1,    1'b1, 99, 0, 1'b0);
      run_imp(32768, 1'b0, 11, 5, 1'b0);
      run_imp(32768, 1'b0, 11, 5, 1'b1);

      // Saturation on the all-0x7F instance, both rails.
      step(0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1, 0);
      for (int j = 0; j < 25; j++)
         step(131071, 1'b1, 1'b1, 1'b0, 1'b0, 0, (j >= 5), 131071);
      for (int j = 0; j < 25; j++)
         step(-131072, 1'b1, 1'b1, 1'b0, 1'b0, 0, (j >= 21), -131072);

      // Golden-model run with random data, strobes and enables.
      step(0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0);
      for (int j = 0; j < 10000; j++) begin
         d = int'($urandom_range(0, 262143)) - 131072;
         step(d, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 9),
              1'b0, 1'b0, 0, 1'b0, 0);
      end
      i_valid = 1'b0;
      i_en    = 1'b0;

      // Bounded drain of the scoreboard.
      repeat (3) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending %0d expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir.md
Name: fir

Overview:
- Parameterised direct-form FIR filter with a FIR_LEN-tap sample delay line and constant coefficients, all signed fixed point.
- Sits in the receive datapath after the channel model and filters one sample per valid strobe.
- Produces a registered, truncated and saturated output sample.

Parameters:
- FIR_LEN, 21, number of taps.
- NB_COEFF, 8, coefficient width: signed S(NB_COEFF, NBF_COEFF).
- NBF_COEFF, 7, coefficient fractional bits.
- NB_IN, 18, input sample width: signed S(NB_IN, NBF_IN).
- NBF_IN, 15, input fractional bits.
- NB_OUT, 18, output width: signed S(NB_OUT, NBF_OUT).
- NBF_OUT, 15, output fractional bits. Must satisfy NBF_OUT <= NBF_IN+NBF_COEFF.
- COEFFS, FIR_LEN*NB_COEFF bits, packed coefficient vector; h[k] = COEFFS[k*NB_COEFF +: NB_COEFF].
  - Default: all taps 0, except h[FIR_LEN/2] = 8'sh40 (0.5) and h[FIR_LEN/2 ± 1] = 8'sh20 (0.25).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_is_data  in  NB_IN  signed input sample.
- i_en  in  1  global enable; 0 freezes all state.
- i_valid  in  1  input sample valid strobe.
- o_sample  out  NB_OUT  signed filtered output, registered.

Behaviour:
- Reset:
  - When i_reset=1 at a rising edge, delay line x[0..FIR_LEN-1] and o_sample clear to 0.
  - Reset has priority over i_en and i_valid, and takes effect mid-stream with no residue from earlier samples.
- Delay line:
  - On an edge with i_en=1 and i_valid=1: x[0] <= i_is_data, and x[k] <= x[k-1] for k = 1..FIR_LEN-1.
  - Otherwise x holds its value.
- Output register:
  - On every edge with i_en=1: o_sample <= sat(trunc(acc)), where acc = sum over k of h[k]*x[k], using the registered (pre-shift) taps.
  - With i_en=0, o_sample holds. i_valid does not gate the output register.
- Latency:
  - A sample presented at edge n enters x[0] at edge n.
  - Its h[k] contribution appears on o_sample after edge n+k+1, given continuous strobes.
  - Impulse response therefore appears at o_sample starting 1 cycle after capture.
- Arithmetic:
  - Each product is full precision: NB_IN+NB_COEFF bits (26) with NBF_IN+NBF_COEFF fractional bits (22).
  - The accumulator adds ceil(log2(FIR_LEN)) guard bits (31 bits at defaults) and never overflows.
- Output quantisation:
  - Drop (NBF_IN+NBF_COEFF-NBF_OUT) LSBs by arithmetic right shift, i.e. truncation toward -inf (7 bits at defaults).
  - Then saturate to NB_OUT signed: clamp to +(2^(NB_OUT-1)-1) = 131071 and -2^(NB_OUT-1) = -131072.
  - No wrap-around is permitted.
- Implementation:
  - The block is purely combinational sum plus registers; no FSM.
  - Multipliers and the adder tree may be generate-based; any adder-tree organisation is acceptable if the result is bit-exact.
  - Any added pipelining must not change the specified latency.
- Boundaries:
  - i_valid=1 with i_en=0 is ignored.
  - Back-to-back strobes are accepted every cycle.
  - A gap in i_valid does not disturb history; the output keeps recomputing from the held taps and is therefore constant.

Test Plan:
- Reset: assert i_reset for 2 cycles with random inputs and i_en=1 -> o_sample=0 and all taps 0. The first output after release reflects only post-reset samples.
- Impulse, default COEFFS: i_is_data=32768 (1.0) for one strobe at edge 0, then 0 with continuous strobes -> o_sample=8192 after edge 10, 16384 after edge 11, 8192 after edge 12, 0 at all other edges.
- Negative truncation: impulse of -1 (18'h3FFFF) -> o_sample=-1 after edges 10, 11 and 12 (floor of -0.25/-0.5 LSB), 0 elsewhere.
- Saturation: COEFFS all 8'sh7F.
  - Constant input 131071 -> o_sample settles at 131071.
  - Constant input -131072 -> o_sample settles at -131072.
- Gating: impulse followed by i_valid=0 for 5 cycles with i_en=1 -> o_sample frozen at its current value; the sequence resumes unchanged when i_valid returns.
- i_en=0 for 5 cycles mid-stream -> o_sample and taps hold; i_valid pulses during that window are ignored.
- Golden model: 10,000 random full-range samples against a bit-exact software model of sum, truncate and saturate -> zero mismatches.
